// File: rtl/fifo_defines_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_defines_pkg
//  Purpose  : Shared definitions for the waveform sample FIFO and its
//             readers: FIFO word width and the DAC reader state encoding.
//  Ports    : none (package)
//  Revision : 1.1 - added rd_state_t for fifo_dac_reader
// ============================================================================
package fifo_defines_pkg;

   // FIFO word width, also the signed sample width.
   localparam int DATA_WIDTH = 16;

   // DAC reader FSM states.
   typedef enum logic [2:0] {
      RD_IDLE  = 3'd0,
      RD_POP   = 3'd1,
      RD_LOAD  = 3'd2,
      RD_SHIFT = 3'd3,
      RD_GAP   = 3'd4
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_dac_reader_sclkgen.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_dac_reader_sclkgen
//  Purpose  : sclk half-period divider for the DAC reader. While enabled it
//             counts div_q+1 clk cycles per half period and raises a
//             one-cycle rise or fall strike at the end of each half period,
//             alternating and starting with a rise. Clears when disabled so
//             every frame starts from a fresh low half period.
//  Ports    : clk, rst (async, active low), en, div_q  -> rise, fall
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_dac_reader_sclkgen #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div_q,
   output logic                 rise,
   output logic                 fall
);

   logic [DIV_WIDTH-1:0] cnt;
   logic                 phase;   // 0: sclk currently low, 1: currently high
   logic                 term;

   assign term = en && (cnt == div_q);
   assign rise = term && !phase;
   assign fall = term &&  phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (term) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_dac_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_dac_reader
//  Purpose  : Sole read-side consumer of the waveform sample FIFO. Pops one
//             signed sample per frame, converts it to offset binary (MSB
//             inverted) and shifts it MSB-first over a 3-wire DAC link.
//  Ports    : clk, rst (async, active low)
//             en_low_i   - active-low stream enable
//             empty_i    - FIFO empty flag
//             data_i     - FIFO read data, valid the cycle after rd_en_o
//             div_i      - sclk half-period minus one (sampled at LOAD)
//             rd_en_o    - one-cycle FIFO pop strobe
//             cs_n_o, sclk_o, sdo_o - DAC serial link
//             busy_o     - FSM not idle
//             underrun_o - one-cycle pulse when starved while enabled
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_dac_reader #(
   parameter int DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_low_i,
   input  logic                  empty_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DIV_WIDTH-1:0]  div_i,
   output logic                  rd_en_o,
   output logic                  cs_n_o,
   output logic                  sclk_o,
   output logic                  sdo_o,
   output logic                  busy_o,
   output logic                  underrun_o
);

   import fifo_defines_pkg::*;

   localparam int                BIT_W    = $clog2(DATA_WIDTH);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   rd_state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [DIV_WIDTH-1:0]  div_q, div_q_nxt;
   logic [DIV_WIDTH-1:0]  gap_cnt, gap_cnt_nxt;
   logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;

   logic rd_en_nxt, cs_n_nxt, sclk_nxt, sdo_nxt, busy_nxt, underrun_nxt;
   logic sclk_rise, sclk_fall;
   logic start_ok;

   fifo_dac_reader_sclkgen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_sclkgen (
      .clk   (clk),
      .rst   (rst),
      .en    (state == RD_SHIFT),
      .div_q (div_q),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   assign start_ok = !en_low_i && !empty_i;

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RD_IDLE;
         shreg      <= '0;
         div_q      <= '0;
         gap_cnt    <= '0;
         bit_cnt    <= '0;
         rd_en_o    <= 1'b0;
         cs_n_o     <= 1'b1;
         sclk_o     <= 1'b0;
         sdo_o      <= 1'b0;
         busy_o     <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         div_q      <= div_q_nxt;
         gap_cnt    <= gap_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         rd_en_o    <= rd_en_nxt;
         cs_n_o     <= cs_n_nxt;
         sclk_o     <= sclk_nxt;
         sdo_o      <= sdo_nxt;
         busy_o     <= busy_nxt;
         underrun_o <= underrun_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and next output values. Outputs are derived from the next
   // state so that the registered pins line up with the state they belong
   // to (rd_en_o high during POP, cs_n_o low during SHIFT, ...).
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      div_q_nxt    = div_q;
      gap_cnt_nxt  = gap_cnt;
      bit_cnt_nxt  = bit_cnt;
      sclk_nxt     = sclk_o;
      sdo_nxt      = sdo_o;
      underrun_nxt = 1'b0;

      case (state)
         RD_IDLE: begin
            if (start_ok) begin
               state_nxt = RD_POP;
            end
         end

         RD_POP: begin
            state_nxt = RD_LOAD;
         end

         RD_LOAD: begin
            // Signed to offset binary is just an MSB flip.
            shreg_nxt   = {~data_i[DATA_WIDTH-1], data_i[DATA_WIDTH-2:0]};
            sdo_nxt     = ~data_i[DATA_WIDTH-1];
            div_q_nxt   = div_i;
            bit_cnt_nxt = '0;
            sclk_nxt    = 1'b0;
            state_nxt   = RD_SHIFT;
         end

         RD_SHIFT: begin
            if (sclk_rise) begin
               sclk_nxt = 1'b1;
            end
            if (sclk_fall) begin
               sclk_nxt = 1'b0;
               if (bit_cnt == LAST_BIT) begin
                  // Last falling edge closes the frame; sdo holds the LSB.
                  gap_cnt_nxt = '0;
                  state_nxt   = RD_GAP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  shreg_nxt   = {shreg[DATA_WIDTH-2:0], 1'b0};
                  sdo_nxt     = shreg[DATA_WIDTH-2];
               end
            end
         end

         RD_GAP: begin
            if (gap_cnt == div_q) begin
               if (start_ok) begin
                  state_nxt = RD_POP;
               end else begin
                  underrun_nxt = !en_low_i;
                  state_nxt    = RD_IDLE;
               end
            end else begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = RD_IDLE;
         end
      endcase

      rd_en_nxt = (state_nxt == RD_POP);
      cs_n_nxt  = (state_nxt != RD_SHIFT);
      busy_nxt  = (state_nxt != RD_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_dac_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_dac_reader
//  Purpose  : Directed self-checking bench for fifo_dac_reader with a small
//             FIFO model and a link monitor that rebuilds each shifted word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_dac_reader;

   localparam int DW = 16;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en_low_i = 1'b1;
   logic          empty_i;
   logic [DW-1:0] data_i = '0;
   logic [VW-1:0] div_i = '0;
   logic          rd_en_o, cs_n_o, sclk_o, sdo_o, busy_o, underrun_o;

   int checks = 0;
   int errors = 0;

   fifo_dac_reader #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en_low_i   (en_low_i),
      .empty_i    (empty_i),
      .data_i     (data_i),
      .div_i      (div_i),
      .rd_en_o    (rd_en_o),
      .cs_n_o     (cs_n_o),
      .sclk_o     (sclk_o),
      .sdo_o      (sdo_o),
      .busy_o     (busy_o),
      .underrun_o (underrun_o)
   );

   always #5 clk = ~clk;

   // FIFO model: data appears the cycle after the pop strobe.
   logic [DW-1:0] mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign empty_i = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (rd_en_o) begin
         data_i <= mem[rd_ptr % 16];
         rd_ptr <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [DW-1:0] v);
      mem[wr_ptr % 16] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   // Link monitor, sampled on the falling clk edge.
   logic          mon_clr = 1'b0;
   int            cyc = 0;
   int            rd_cnt, und_cnt, rise_total, cs_low, frames;
   logic          busy_at_und, prev_sclk, prev_cs;
   logic [DW-1:0] cap;
   logic [DW-1:0] frame_word [0:7];
   int            frame_len  [0:7];
   int            fall_cyc   [0:7];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mon_clr) begin
         rd_cnt = 0; und_cnt = 0; rise_total = 0; cs_low = 0; frames = 0;
         busy_at_und = 1'bx; cap = '0;
         for (int k = 0; k < 8; k++) begin
            frame_word[k] = 'x; frame_len[k] = -1; fall_cyc[k] = -1;
         end
      end else begin
         if (rd_en_o) rd_cnt = rd_cnt + 1;
         if (underrun_o) begin
            und_cnt = und_cnt + 1;
            busy_at_und = busy_o;
         end
         if (sclk_o && !prev_sclk) begin
            cap = {cap[DW-2:0], sdo_o};
            rise_total = rise_total + 1;
         end
         if (!cs_n_o) cs_low = cs_low + 1;
         if (!cs_n_o && prev_cs && frames < 8) fall_cyc[frames] = cyc;
         if (cs_n_o && !prev_cs && frames < 8) begin
            frame_word[frames] = cap;
            frame_len[frames]  = cs_low;
            cs_low = 0;
            frames = frames + 1;
         end
      end
      prev_sclk = sclk_o;
      prev_cs   = cs_n_o;
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   initial begin
      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      check("rst_rd_en",    32'(rd_en_o),    32'd0);
      check("rst_cs_n",     32'(cs_n_o),     32'd1);
      check("rst_sclk",     32'(sclk_o),     32'd0);
      check("rst_sdo",      32'(sdo_o),      32'd0);
      check("rst_busy",     32'(busy_o),     32'd0);
      check("rst_underrun", 32'(underrun_o), 32'd0);
      rst = 1'b1;
      clear_mon();

      // ---------------- single sample 0x0000, div 0 ----------------
      @(negedge clk);
      push(16'h0000);
      div_i    = 8'd0;
      en_low_i = 1'b0;
      @(negedge clk);
      check("t1_pop_rd_en", 32'(rd_en_o), 32'd1);
      check("t1_pop_busy",  32'(busy_o),  32'd1);
      @(negedge clk);
      check("t1_load_rd_en", 32'(rd_en_o), 32'd0);
      check("t1_load_cs_n",  32'(cs_n_o),  32'd1);
      @(negedge clk);
      check("t1_shift_cs_n", 32'(cs_n_o), 32'd0);
      check("t1_shift_sdo",  32'(sdo_o),  32'd1);
      for (int i = 0; i < 100 && und_cnt == 0; i++) @(negedge clk);
      check("t1_underrun_cnt", 32'(und_cnt),       32'd1);
      check("t1_word",         32'(frame_word[0]), 32'h8000);
      check("t1_cs_low",       32'(frame_len[0]),  32'd32);
      check("t1_rd_cnt",       32'(rd_cnt),        32'd1);
      check("t1_busy_at_und",  32'(busy_at_und),   32'd0);
      check("t1_frames",       32'(frames),        32'd1);
      en_low_i = 1'b1;
      @(negedge clk);

      // ---------------- extremes, div 1 ----------------
      clear_mon();
      push(16'h8000);
      push(16'h7FFF);
      div_i    = 8'd1;
      en_low_i = 1'b0;
      for (int i = 0; i < 300 && und_cnt == 0; i++) @(negedge clk);
      check("t2_underrun_cnt", 32'(und_cnt),       32'd1);
      check("t2_word0",        32'(frame_word[0]), 32'h0000);
      check("t2_word1",        32'(frame_word[1]), 32'hFFFF);
      check("t2_cs_low0",      32'(frame_len[0]),  32'd64);
      check("t2_cs_low1",      32'(frame_len[1]),  32'd64);
      check("t2_period",       32'(fall_cyc[1] - fall_cyc[0]), 32'd68);
      check("t2_rd_cnt",       32'(rd_cnt),        32'd2);
      en_low_i = 1'b1;
      @(negedge clk);

      // ---------------- disable mid-frame ----------------
      clear_mon();
      push(16'h1234);
      push(16'h5678);
      div_i    = 8'd0;
      en_low_i = 1'b0;
      for (int i = 0; i < 100 && rise_total < 5; i++) @(negedge clk);
      check("t3_reached_bit5", 32'(rise_total), 32'd5);
      en_low_i = 1'b1;
      for (int i = 0; i < 100 && !(frames == 1 && !busy_o); i++) @(negedge clk);
      repeat (10) @(negedge clk);
      check("t3_frames",   32'(frames),        32'd1);
      check("t3_word",     32'(frame_word[0]), 32'h9234);
      check("t3_rd_cnt",   32'(rd_cnt),        32'd1);
      check("t3_underrun", 32'(und_cnt),       32'd0);
      check("t3_busy",     32'(busy_o),        32'd0);

      // ---------------- reset mid-frame (0x5678 still queued) ----------------
      clear_mon();
      en_low_i = 1'b0;
      for (int i = 0; i < 100 && rise_total < 3; i++) @(negedge clk);
      check("t4_reached_bit3", 32'(rise_total), 32'd3);
      check("t4_in_frame", 32'(cs_n_o), 32'd0);
      rst = 1'b0;
      #1;
      check("t4_rst_cs_n", 32'(cs_n_o), 32'd1);
      check("t4_rst_sclk", 32'(sclk_o), 32'd0);
      check("t4_rst_sdo",  32'(sdo_o),  32'd0);
      check("t4_rst_busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      clear_mon();
      push(16'hABCD);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 100 && !(frames == 1 && !busy_o); i++) @(negedge clk);
      check("t4_frames", 32'(frames),        32'd1);
      check("t4_word",   32'(frame_word[0]), 32'h2BCD);
      check("t4_rd_cnt", 32'(rd_cnt),        32'd1);
      en_low_i = 1'b1;
      @(negedge clk);

      // ---------------- div change mid-frame ----------------
      clear_mon();
      push(16'h00FF);
      push(16'h0F0F);
      div_i    = 8'd0;
      en_low_i = 1'b0;
      for (int i = 0; i < 100 && rise_total < 4; i++) @(negedge clk);
      div_i = 8'd3;
      for (int i = 0; i < 400 && und_cnt == 0; i++) @(negedge clk);
      check("t5_underrun_cnt", 32'(und_cnt),       32'd1);
      check("t5_cs_low0",      32'(frame_len[0]),  32'd32);
      check("t5_cs_low1",      32'(frame_len[1]),  32'd128);
      check("t5_word0",        32'(frame_word[0]), 32'h80FF);
      check("t5_word1",        32'(frame_word[1]), 32'h8F0F);
      en_low_i = 1'b1;
      @(negedge clk);

      // ---------------- empty guard ----------------
      clear_mon();
      en_low_i = 1'b0;
      repeat (100) @(negedge clk);
      check("t6_rd_cnt",   32'(rd_cnt),  32'd0);
      check("t6_underrun", 32'(und_cnt), 32'd0);
      check("t6_cs_low",   32'(cs_low),  32'd0);
      check("t6_cs_n",     32'(cs_n_o),  32'd1);
      check("t6_busy",     32'(busy_o),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_dac_reader.md
# fifo_dac_reader

Read-side consumer of the waveform sample FIFO. The function generator writes signed samples into the FIFO. This block pops them one at a time, converts each one to offset binary and shifts it out MSB-first on a 3-wire serial DAC link (cs_n/sclk/sdo). It sits between the FIFO read port and the chip-level DAC pins, and is the only FIFO reader.

## Interface
- DATA_WIDTH, default from fifo_defines_pkg (16): sample width, equal to the FIFO word width
- DIV_WIDTH, default 8: width of the sclk half-period divider
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- en_low_i  in  1  active-low stream enable
- empty_i  in  1  FIFO empty flag
- data_i  in  DATA_WIDTH  FIFO read data, signed; valid the cycle after rd_en_o
- div_i  in  DIV_WIDTH  sclk half-period minus one, in clk cycles
- rd_en_o  out  1  FIFO pop strobe, one-cycle pulse
- cs_n_o  out  1  DAC chip select, active low
- sclk_o  out  1  DAC serial clock, idle low
- sdo_o  out  1  DAC serial data
- busy_o  out  1  high in any state other than IDLE
- underrun_o  out  1  one-cycle pulse on starvation while enabled

## Operation
- All outputs are registered. Reset values: rd_en_o=0, cs_n_o=1, sclk_o=0, sdo_o=0, busy_o=0, underrun_o=0, FSM=IDLE, counters=0.
- FSM states are IDLE, POP, LOAD, SHIFT, GAP.
- **IDLE:** if !en_low_i && !empty_i, go to POP.
- **POP:**
  - rd_en_o=1 for exactly this cycle.
  - Go to LOAD.
- **LOAD:**
  - Capture data_i with the MSB inverted (signed to offset binary: 0x8000→0x0000, 0x0000→0x8000, 0x7FFF→0xFFFF).
  - Latch div_i into div_q.
  - Drive sdo_o = bit DATA_WIDTH-1.
  - Go to SHIFT.
- **SHIFT:**
  - cs_n_o=0.
  - sclk_o toggles every div_q+1 clk cycles.
  - sdo_o changes only on the cycle sclk_o falls; the DAC samples on sclk rising.
  - After the DATA_WIDTH-th falling edge, go to GAP with sclk_o=0.
- **GAP:**
  - cs_n_o=1 for div_q+1 cycles.
  - At the end of GAP:
    - !en_low_i && !empty_i: go to POP.
    - !en_low_i && empty_i: pulse underrun_o and go to IDLE.
    - en_low_i: go to IDLE with no underrun.
- Deasserting the enable mid-frame does not truncate the frame. The current word completes and the block returns to IDLE after GAP.
- div_i changes take effect only at the next LOAD.
- The block never asserts rd_en_o while empty_i=1. At most one pop is outstanding per frame.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously. The partial word is discarded and not re-read.

## Timing
- Enable/data to pop: IDLE with a qualifying en_low_i/empty_i in cycle N gives POP (rd_en_o=1) in cycle N+1 and LOAD in N+2.
- cs_n_o falls in N+3 (first SHIFT cycle).
- cs_n_o low for exactly 2·DATA_WIDTH·(div_q+1) cycles.
- Frame period for back-to-back samples: 2·DATA_WIDTH·(div_q+1) + (div_q+1) + 2 cycles (GAP + POP + LOAD).
- With div_i=0, DATA_WIDTH=16: 32 cycles cs_n low, 35-cycle frame period.
- underrun_o is asserted in the same cycle the FSM returns to IDLE.

## Structure
- fifo_defines_pkg (existing) holds DATA_WIDTH and a new typedef enum logic [2:0] rd_state_t {RD_IDLE, RD_POP, RD_LOAD, RD_SHIFT, RD_GAP}.
- One sub-module, fifo_dac_reader_sclkgen: a divider counter that produces sclk rise/fall strikes from div_q and is enabled only in SHIFT.
- The shift register, bit counter and FSM live in the top.

## Test plan
- **Single sample:** reset, FIFO holds 0x0000, div_i=0, en_low_i=0.
  - rd_en_o is pulsed once.
  - sdo_o stream is 1000_0000_0000_0000.
  - cs_n_o is low for 32 cycles, then underrun_o pulses once and busy_o drops.
- **Extremes:** FIFO holds 0x8000 then 0x7FFF, div_i=1.
  - Streams are 0x0000 then 0xFFFF.
  - Each frame has cs_n_o low for 64 cycles; frames are back-to-back with a 2-cycle GAP.
- **Disable mid-frame:** en_low_i goes 1 at bit 5 of a 0x1234 frame (FIFO non-empty).
  - The full word 0x9234 is shifted out.
  - The block goes to IDLE, there is no second rd_en_o, and underrun_o stays 0.
- **Reset mid-frame:** rst goes low during SHIFT.
  - In the same cycle: cs_n_o=1, sclk_o=0, sdo_o=0, busy_o=0.
  - After release, the next FIFO word is read (new rd_en_o) and the partial word is not repeated.
- **div_i change:** div_i changes from 0 to 3 mid-frame.
  - The current frame keeps a half-period of 1.
  - The next frame uses a half-period of 4 cycles.
- **Empty guard:** empty_i=1 with en_low_i=0 for 100 cycles.
  - rd_en_o stays 0, cs_n_o stays 1, and underrun_o never pulses from IDLE.
